// File: rtl/gate_tt_checker.sv
// gate_tt_checker
//   Consumer of a 2-input gate stage. It samples (a, b, c) triples while in
//   RUN and checks each c against the expected truth table GATE_OP, where
//   bit index = {a,b}. It also captures the observed table, counts
//   mismatches and flags conflicting results. When all four {a,b}
//   combinations have been seen, it reports done/pass.
//
//   Optional feature: define GATE_TT_TIMEOUT_EN to build a RUN-cycle
//   counter. After TIMEOUT cycles in RUN without full coverage, the block
//   forces a failing completion.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start_i        in   1-cycle pulse: clear results, enter RUN
//   in_valid_i     in   in_a_i/in_b_i/in_c_i valid this cycle
//   in_a_i         in   gate input a
//   in_b_i         in   gate input b
//   in_c_i         in   gate output c
//   busy_o         out  high while in RUN
//   done_o         out  1-cycle pulse on completion
//   pass_o         out  result, held until next start
//   seen_mask_o    out  [4] bit {a,b} set once that combination is sampled
//   tt_captured_o  out  [4] last c observed per combination
//   mismatch_cnt_o out  [CNT_W] saturating count of c != GATE_OP[{a,b}]
//   conflict_o     out  sticky: same {a,b} produced two different c values
//   timeout_o      out  sticky timeout flag (0 without GATE_TT_TIMEOUT_EN)
module gate_tt_checker #(
    parameter logic [3:0] GATE_OP = 4'b1000,
    parameter int         CNT_W   = 8,
    parameter int         TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             in_valid_i,
    input  logic             in_a_i,
    input  logic             in_b_i,
    input  logic             in_c_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [3:0]       seen_mask_o,
    output logic [3:0]       tt_captured_o,
    output logic [CNT_W-1:0] mismatch_cnt_o,
    output logic             conflict_o,
    output logic             timeout_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    logic             busy_q, done_q, pass_q, conflict_q, timeout_q;
    logic [3:0]       seen_q, tt_q;
    logic [CNT_W-1:0] cnt_q;

    // Results of applying the current sample, used only when a RUN sample is taken
    logic [1:0]       idx;
    logic [3:0]       seen_d, tt_d;
    logic [CNT_W-1:0] cnt_d;
    logic             conflict_d;
    logic             complete;

    always_comb begin
        idx        = {in_a_i, in_b_i};
        seen_d     = seen_q | (4'b0001 << idx);
        tt_d       = tt_q;
        tt_d[idx]  = in_c_i;
        cnt_d      = cnt_q;
        if ((in_c_i != GATE_OP[idx]) && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + 1'b1;
        // Conflict compares against the previously captured value, before overwrite
        conflict_d = conflict_q | (seen_q[idx] & (tt_q[idx] != in_c_i));
        complete   = in_valid_i && (seen_d == 4'hF);
    end

`ifdef GATE_TT_TIMEOUT_EN
    localparam int CYC_W = $clog2(TIMEOUT + 1);
    localparam logic [CYC_W-1:0] TIMEOUT_V = CYC_W'(TIMEOUT);
    logic [CYC_W-1:0] cyc_q;
    logic [CYC_W-1:0] cyc_d;
    assign cyc_d = cyc_q + 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            conflict_q <= 1'b0;
            timeout_q  <= 1'b0;
            seen_q     <= 4'h0;
            tt_q       <= 4'h0;
            cnt_q      <= '0;
`ifdef GATE_TT_TIMEOUT_EN
            cyc_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                // start wins over any sample presented in the same cycle
                state_q    <= RUN;
                busy_q     <= 1'b1;
                pass_q     <= 1'b0;
                conflict_q <= 1'b0;
                timeout_q  <= 1'b0;
                seen_q     <= 4'h0;
                tt_q       <= 4'h0;
                cnt_q      <= '0;
`ifdef GATE_TT_TIMEOUT_EN
                cyc_q      <= '0;
`endif
            end else begin
                case (state_q)
                    RUN: begin
                        if (in_valid_i) begin
                            seen_q     <= seen_d;
                            tt_q       <= tt_d;
                            cnt_q      <= cnt_d;
                            conflict_q <= conflict_d;
                        end
`ifdef GATE_TT_TIMEOUT_EN
                        cyc_q <= cyc_d;
`endif
                        if (complete) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (cnt_d == '0) && !conflict_d;
                        end
`ifdef GATE_TT_TIMEOUT_EN
                        // A completing sample in the timeout cycle takes priority
                        else if (cyc_d == TIMEOUT_V) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            pass_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end
`endif
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pass_o         = pass_q;
    assign seen_mask_o    = seen_q;
    assign tt_captured_o  = tt_q;
    assign mismatch_cnt_o = cnt_q;
    assign conflict_o     = conflict_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb_gate_tt_checker
//   Directed-vector bench for gate_tt_checker with an AND truth table,
//   CNT_W=2 and TIMEOUT=8. Expected values are hand-computed.
module tb_gate_tt_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, in_valid, in_a, in_b, in_c;
    logic       busy, done, pass, conflict, timeout;
    logic [3:0] seen, tt;
    logic [1:0] cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gate_tt_checker #(
        .GATE_OP (4'b1000),
        .CNT_W   (2),
        .TIMEOUT (8)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .in_valid_i     (in_valid),
        .in_a_i         (in_a),
        .in_b_i         (in_b),
        .in_c_i         (in_c),
        .busy_o         (busy),
        .done_o         (done),
        .pass_o         (pass),
        .seen_mask_o    (seen),
        .tt_captured_o  (tt),
        .mismatch_cnt_o (cnt),
        .conflict_o     (conflict),
        .timeout_o      (timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one active edge; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic sample(input logic a, input logic b, input logic c);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_c = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic bz, input logic dn, input logic ps,
                             input logic [3:0] sm, input logic [3:0] t, input logic [1:0] c,
                             input logic cf);
        check_eq({tag, ".busy"}, 32'(busy), 32'(bz));
        check_eq({tag, ".done"}, 32'(done), 32'(dn));
        check_eq({tag, ".pass"}, 32'(pass), 32'(ps));
        check_eq({tag, ".seen"}, 32'(seen), 32'(sm));
        check_eq({tag, ".tt"}, 32'(tt), 32'(t));
        check_eq({tag, ".cnt"}, 32'(cnt), 32'(c));
        check_eq({tag, ".conflict"}, 32'(conflict), 32'(cf));
    endtask

    initial begin
        bit saw_done;
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_a = 1'b0;
        in_b = 1'b0;
        in_c = 1'b0;
        tick();
        tick();
        check_all("reset", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        check_eq("reset.timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        tick();

        // Correct AND table, with an ignored sample presented alongside start
        in_valid = 1'b1;
        in_a = 1'b0;
        in_b = 1'b0;
        in_c = 1'b1;
        do_start();
        in_valid = 1'b0;
        check_all("start", 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        sample(0, 0, 0);
        sample(1, 0, 0);
        sample(0, 1, 0);
        check_all("and.mid", 1'b1, 1'b0, 1'b0, 4'b0111, 4'b0000, 2'd0, 1'b0);
        sample(1, 1, 1);
        check_all("and.done", 1'b0, 1'b1, 1'b1, 4'hF, 4'b1000, 2'd0, 1'b0);
        tick();
        check_all("and.idle", 1'b0, 1'b0, 1'b1, 4'hF, 4'b1000, 2'd0, 1'b0);

        // An OR-behaving stage checked against the AND table
        do_start();
        sample(0, 0, 0);
        sample(1, 0, 1);
        sample(0, 1, 1);
        sample(1, 1, 1);
        check_all("or.done", 1'b0, 1'b1, 1'b0, 4'hF, 4'b1110, 2'd2, 1'b0);
        tick();

        // Conflicting results on the same combination
        do_start();
        sample(1, 1, 1);
        sample(1, 1, 0);
        check_all("conf.mid", 1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000, 2'd1, 1'b1);
        sample(0, 0, 0);
        sample(0, 1, 0);
        sample(1, 0, 0);
        check_all("conf.done", 1'b0, 1'b1, 1'b0, 4'hF, 4'b0000, 2'd1, 1'b1);
        tick();

        // Saturating counter, then in_valid ignored while IDLE
        do_start();
        for (int i = 0; i < 5; i++) sample(0, 0, 1);
        check_all("sat.mid", 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 2'd3, 1'b0);
        sample(0, 1, 0);
        sample(1, 0, 0);
        sample(1, 1, 1);
        check_all("sat.done", 1'b0, 1'b1, 1'b0, 4'hF, 4'b1001, 2'd3, 1'b0);
        tick();
        sample(1, 1, 0);
        sample(0, 0, 0);
        check_all("idle.ign", 1'b0, 1'b0, 1'b0, 4'hF, 4'b1001, 2'd3, 1'b0);

        // Asynchronous reset mid-RUN
        do_start();
        sample(0, 0, 1);
        sample(1, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst.mid", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check_eq("rst.nodone", 32'(saw_done), 32'd0);
        rst_n = 1'b1;
        tick();
        do_start();
        sample(1, 1, 1);
        sample(0, 1, 0);
        sample(0, 0, 0);
        sample(1, 0, 0);
        check_all("rst.after", 1'b0, 1'b1, 1'b1, 4'hF, 4'b1000, 2'd0, 1'b0);
        tick();

        // Incomplete coverage
        do_start();
        sample(0, 0, 0);
`ifdef GATE_TT_TIMEOUT_EN
        // start edge E0, sample edge E1, the counter reaches 8 at edge E8
        k = 0;
        saw_done = 1'b0;
        while (!saw_done && k < 20) begin
            tick();
            k++;
            if (done) saw_done = 1'b1;
        end
        check_eq("to.done", 32'(saw_done), 32'd1);
        check_eq("to.cycles", 32'(k), 32'd7);
        check_eq("to.timeout", 32'(timeout), 32'd1);
        check_eq("to.pass", 32'(pass), 32'd0);
        check_eq("to.seen", 32'(seen), 32'h1);
        check_eq("to.busy", 32'(busy), 32'd0);
        tick();
        check_eq("to.idle_done", 32'(done), 32'd0);
`else
        saw_done = 1'b0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) saw_done = 1'b1;
            k++;
        end
        check_eq("wait.nodone", 32'(saw_done), 32'd0);
        check_eq("wait.busy", 32'(busy), 32'd1);
        check_eq("wait.timeout", 32'(timeout), 32'd0);
        check_eq("wait.seen", 32'(seen), 32'h1);
`endif

        // A new start from any state clears everything
        do_start();
        check_all("restart", 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        check_eq("restart.timeout", 32'(timeout), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
